// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - signal bundle between the sdram arbiter, its requesters and the controller
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  // ROM download byte stream
  logic [19:0]           ioctl_addr;
  logic [7:0]            ioctl_data;
  logic                  ioctl_wr;
  logic                  ioctl_download;
  logic                  dl_busy;
  // four read requesters
  logic [3:0]            port_req;
  logic [ADDR_WIDTH-1:0] port_addr_0;
  logic [ADDR_WIDTH-1:0] port_addr_1;
  logic [ADDR_WIDTH-1:0] port_addr_2;
  logic [ADDR_WIDTH-1:0] port_addr_3;
  logic [3:0]            port_ack;
  logic [3:0]            port_valid;
  logic [DATA_WIDTH-1:0] port_data_0;
  logic [DATA_WIDTH-1:0] port_data_1;
  logic [DATA_WIDTH-1:0] port_data_2;
  logic [DATA_WIDTH-1:0] port_data_3;
  // shared SDRAM controller port
  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic [DATA_WIDTH-1:0] sdram_data;
  logic                  sdram_we;
  logic                  sdram_req;
  logic                  sdram_ack;
  logic                  sdram_valid;
  logic [DATA_WIDTH-1:0] sdram_q;

  // arbiter side
  modport master (
    input  ioctl_addr, ioctl_data, ioctl_wr, ioctl_download,
    input  port_req, port_addr_0, port_addr_1, port_addr_2, port_addr_3,
    input  sdram_ack, sdram_valid, sdram_q,
    output dl_busy, port_ack, port_valid,
    output port_data_0, port_data_1, port_data_2, port_data_3,
    output sdram_addr, sdram_data, sdram_we, sdram_req
  );

  // requester / controller side
  modport slave (
    output ioctl_addr, ioctl_data, ioctl_wr, ioctl_download,
    output port_req, port_addr_0, port_addr_1, port_addr_2, port_addr_3,
    output sdram_ack, sdram_valid, sdram_q,
    input  dl_busy, port_ack, port_valid,
    input  port_data_0, port_data_1, port_data_2, port_data_3,
    input  sdram_addr, sdram_data, sdram_we, sdram_req
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one SDRAM controller between ROM download writes and four round-robin readers
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  sdram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic                  sdram_req_q, sdram_req_d;
  logic                  sdram_we_q, sdram_we_d;
  logic [ADDR_WIDTH-1:0] sdram_addr_q, sdram_addr_d;
  logic [DATA_WIDTH-1:0] sdram_data_q, sdram_data_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [3:0]            port_ack_q, port_ack_d;
  logic [3:0]            port_valid_q, port_valid_d;
  logic [DATA_WIDTH-1:0] port_data_q [4];
  logic [DATA_WIDTH-1:0] port_data_d [4];
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  acc_any_q, acc_any_d;
  logic [17:0]           acc_addr_q, acc_addr_d;
  logic                  dl_q, dl_d;

  logic                  word_done;
  logic [17:0]           done_addr;
  logic [DATA_WIDTH-1:0] done_data;
  logic [DATA_WIDTH-1:0] merged;
  logic                  grant_found;
  logic [1:0]            grant_idx;
  logic [1:0]            probe;
  logic [ADDR_WIDTH-1:0] grant_addr;

  // Byte packer: merge each strobed byte into its lane; lane 3 or the end of download completes a word.
  always_comb begin
    acc_d      = acc_q;
    acc_any_d  = acc_any_q;
    acc_addr_d = acc_addr_q;
    dl_d       = bus.ioctl_download;
    word_done  = 1'b0;
    done_addr  = acc_addr_q;
    done_data  = acc_q;
    merged     = acc_q;
    merged[{bus.ioctl_addr[1:0], 3'b000} +: 8] = bus.ioctl_data;
    if (bus.ioctl_wr && bus.ioctl_download) begin
      if (bus.ioctl_addr[1:0] == 2'd3) begin
        word_done = 1'b1;
        done_addr = bus.ioctl_addr[19:2];
        done_data = merged;
        acc_d     = '0;
        acc_any_d = 1'b0;
      end else begin
        acc_d      = merged;
        acc_any_d  = 1'b1;
        acc_addr_d = bus.ioctl_addr[19:2];
      end
    end else if (dl_q && !bus.ioctl_download && acc_any_q) begin
      // download ended mid-word: flush what we have, unwritten lanes stay zero
      word_done = 1'b1;
      acc_d     = '0;
      acc_any_d = 1'b0;
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    probe       = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      probe = last_grant_q + 2'(i);
      if (!grant_found && bus.port_req[probe]) begin
        grant_found = 1'b1;
        grant_idx   = probe;
      end
    end
    case (grant_idx)
      2'd0:    grant_addr = bus.port_addr_0;
      2'd1:    grant_addr = bus.port_addr_1;
      2'd2:    grant_addr = bus.port_addr_2;
      default: grant_addr = bus.port_addr_3;
    endcase
  end

  // Transaction FSM: pending download word first, reads only outside download, one access at a time.
  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_we_d   = sdram_we_q;
    sdram_addr_d = sdram_addr_q;
    sdram_data_d = sdram_data_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    port_ack_d   = '0;
    port_valid_d = '0;
    port_data_d  = port_data_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          sdram_addr_d = pend_addr_q;
          sdram_data_d = pend_data_q;
          sdram_we_d   = 1'b1;
          sdram_req_d  = 1'b1;
          state_d      = REQ;
        end else if (!bus.ioctl_download && !dl_q && grant_found) begin
          // dl_q guard keeps the end-of-download flush ahead of any read
          sdram_addr_d = grant_addr;
          sdram_we_d   = 1'b0;
          owner_d      = grant_idx;
          sdram_req_d  = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          if (sdram_we_q) begin
            sdram_we_d = 1'b0;
            pend_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            port_ack_d[owner_q] = 1'b1;
            last_grant_d        = owner_q;
            state_d             = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.sdram_valid) begin
          port_data_d[owner_q]  = bus.sdram_q;
          port_valid_d[owner_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a freshly completed word wins over the ack clearing pending (overrun replaces the old word)
    if (word_done) begin
      pend_d      = 1'b1;
      pend_addr_d = ADDR_WIDTH'({done_addr, 1'b0});
      pend_data_d = done_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sdram_req_q  <= 1'b0;
      sdram_we_q   <= 1'b0;
      sdram_addr_q <= '0;
      sdram_data_q <= '0;
      owner_q      <= 2'd0;
      last_grant_q <= 2'd3;
      port_ack_q   <= '0;
      port_valid_q <= '0;
      for (int i = 0; i < 4; i++) port_data_q[i] <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      acc_q        <= '0;
      acc_any_q    <= 1'b0;
      acc_addr_q   <= '0;
      dl_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_we_q   <= sdram_we_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_data_q <= sdram_data_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      port_ack_q   <= port_ack_d;
      port_valid_q <= port_valid_d;
      port_data_q  <= port_data_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      acc_q        <= acc_d;
      acc_any_q    <= acc_any_d;
      acc_addr_q   <= acc_addr_d;
      dl_q         <= dl_d;
    end
  end

  assign bus.sdram_req   = sdram_req_q;
  assign bus.sdram_we    = sdram_we_q;
  assign bus.sdram_addr  = sdram_addr_q;
  assign bus.sdram_data  = sdram_data_q;
  assign bus.port_ack    = port_ack_q;
  assign bus.port_valid  = port_valid_q;
  assign bus.port_data_0 = port_data_q[0];
  assign bus.port_data_1 = port_data_q[1];
  assign bus.port_data_2 = port_data_q[2];
  assign bus.port_data_3 = port_data_q[3];
  assign bus.dl_busy     = pend_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if bus ();
  sdram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [22:0] PA0 = 23'h000010;
  localparam logic [22:0] PA1 = 23'h000022;
  localparam logic [22:0] PA2 = 23'h000100;
  localparam logic [22:0] PA3 = 23'h0003F0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // controller memory contents: one preloaded word, everything else derived from the address
  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'h000100) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          we;
    logic [22:0] addr;
    logic [31:0] data;
    int          owner;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur_t;

  function automatic txn_t rd(input int k, input logic [22:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.data = '0; t.owner = k;
    return t;
  endfunction

  function automatic txn_t wr(input logic [22:0] a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.data = d; t.owner = -1;
    return t;
  endfunction

  logic [3:0]  exp_ack = '0;
  logic [3:0]  exp_valid = '0;
  logic [31:0] exp_data [4] = '{default: 32'h0};
  bit          inflight = 1'b0;
  int          inf_owner = 0;
  bit          mon_on = 1'b0;
  bit          prev_req = 1'b0;
  int          ack_cnt [4] = '{default: 0};
  int          valid_cnt [4] = '{default: 0};
  int          last_ack_cyc [4] = '{default: 0};
  int          last_valid_cyc [4] = '{default: 0};
  int          last_wr_cyc = 0;
  int          grant_log[$];
  int          rise_log[$];
  int          sv_log[$];

  // Compare DUT outputs with the model every cycle, then advance the model on this cycle's events.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("port_ack", bus.port_ack, exp_ack);
      chk("port_valid", bus.port_valid, exp_valid);
      chk("port_data_0", bus.port_data_0, exp_data[0]);
      chk("port_data_1", bus.port_data_1, exp_data[1]);
      chk("port_data_2", bus.port_data_2, exp_data[2]);
      chk("port_data_3", bus.port_data_3, exp_data[3]);
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.port_ack[k] === 1'b1) begin
        ack_cnt[k]++;
        last_ack_cyc[k] = cyc;
        grant_log.push_back(k);
      end
      if (bus.port_valid[k] === 1'b1) begin
        valid_cnt[k]++;
        last_valid_cyc[k] = cyc;
      end
    end
    exp_ack   = '0;
    exp_valid = '0;
    if (reset) begin
      inflight = 1'b0;
      prev_req = 1'b0;
      for (int k = 0; k < 4; k++) exp_data[k] = '0;
    end else begin
      if (bus.sdram_req && !prev_req) rise_log.push_back(cyc);
      prev_req = bus.sdram_req;
      if (bus.sdram_req && bus.sdram_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: actual addr=%0h we=%0b, required none", bus.sdram_addr, bus.sdram_we);
        end else begin
          cur_t = exp_q.pop_front();
          chk("txn_we", bus.sdram_we, cur_t.we);
          chk("txn_addr", bus.sdram_addr, cur_t.addr);
          if (cur_t.we) begin
            chk("txn_wdata", bus.sdram_data, cur_t.data);
            last_wr_cyc = cyc;
          end else begin
            exp_ack[cur_t.owner] = 1'b1;
            inflight  = 1'b1;
            inf_owner = cur_t.owner;
          end
        end
      end
      if (bus.sdram_valid && inflight) begin
        exp_data[inf_owner]  = bus.sdram_q;
        exp_valid[inf_owner] = 1'b1;
        inflight = 1'b0;
        sv_log.push_back(cyc);
      end
    end
  end

  // ---------------- SDRAM controller emulation ----------------
  int ack_dly = 3;
  int val_dly = 5;
  bit ctl_en = 1'b1;
  bit force_valid = 1'b0;

  initial begin
    int phase;
    int cnt;
    logic [22:0] a;
    phase = 0;
    cnt = 0;
    a = '0;
    bus.sdram_ack = 1'b0;
    bus.sdram_valid = 1'b0;
    bus.sdram_q = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.sdram_ack = 1'b0;
      bus.sdram_valid = 1'b0;
      if (reset || !ctl_en) begin
        phase = 0;
        cnt = 0;
        bus.sdram_valid = force_valid;
      end else if (phase == 0) begin
        if (bus.sdram_req) begin
          if (cnt == ack_dly) begin
            bus.sdram_ack = 1'b1;
            a = bus.sdram_addr;
            phase = bus.sdram_we ? 0 : 1;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end else begin
        cnt++;
        if (cnt == val_dly) begin
          bus.sdram_valid = 1'b1;
          bus.sdram_q = mem_word(a);
          phase = 0;
          cnt = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ack(input int k, input int target, input string name);
    for (int i = 0; i < 200 && ack_cnt[k] < target; i++) tick();
    if (ack_cnt[k] < target) fail_timeout(name);
  endtask

  task automatic wait_valid(input int k, input int target, input string name);
    for (int i = 0; i < 200 && valid_cnt[k] < target; i++) tick();
    if (valid_cnt[k] < target) fail_timeout(name);
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int t0, c, a0, v0, a1, v1, a2, v2, a3, v3;
    bus.ioctl_addr = '0;
    bus.ioctl_data = '0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.port_req = '0;
    bus.port_addr_0 = PA0;
    bus.port_addr_1 = PA1;
    bus.port_addr_2 = PA2;
    bus.port_addr_3 = PA3;

    // reset values
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_sdram_req", bus.sdram_req, 0);
    chk("rst_sdram_we", bus.sdram_we, 0);
    chk("rst_sdram_addr", bus.sdram_addr, 0);
    chk("rst_sdram_data", bus.sdram_data, 0);
    chk("rst_port_ack", bus.port_ack, 0);
    chk("rst_port_valid", bus.port_valid, 0);
    chk("rst_port_data_2", bus.port_data_2, 0);
    chk("rst_dl_busy", bus.dl_busy, 0);
    reset = 1'b0;
    mon_on = 1'b1;
    tick();

    // round robin from reset: 0,1,2,3,0
    grant_log.delete(); rise_log.delete(); sv_log.delete();
    exp_q.push_back(rd(0, PA0));
    exp_q.push_back(rd(1, PA1));
    exp_q.push_back(rd(2, PA2));
    exp_q.push_back(rd(3, PA3));
    exp_q.push_back(rd(0, PA0));
    t0 = cyc;
    bus.port_req = 4'hF;
    wait_ack(0, 2, "rr_acks");
    bus.port_req = 4'h0;
    wait_valid(0, 2, "rr_valids");
    tick();
    chk("rr_grant_count", grant_log.size(), 5);
    if (grant_log.size() >= 5) begin
      chk("rr_grant0", grant_log[0], 0);
      chk("rr_grant1", grant_log[1], 1);
      chk("rr_grant2", grant_log[2], 2);
      chk("rr_grant3", grant_log[3], 3);
      chk("rr_grant4", grant_log[4], 0);
    end
    chk("rr_first_req_latency", (rise_log.size() > 0) ? rise_log[0] - t0 : -1, 1);
    chk("rr_back_to_back", (rise_log.size() >= 5 && sv_log.size() >= 4) ? rise_log[4] - sv_log[3] : -1, 2);
    chk("rr_acks_port1", ack_cnt[1], 1);
    chk("rr_acks_port3", ack_cnt[3], 1);
    chk("rr_data_0", bus.port_data_0, 32'hC0DE0010);
    chk("rr_data_3", bus.port_data_3, 32'hC0DE03F0);
    chk("rr_queue_drained", exp_q.size(), 0);

    // single read on port 2
    a2 = ack_cnt[2]; v2 = valid_cnt[2];
    exp_q.push_back(rd(2, PA2));
    t0 = cyc;
    bus.port_req = 4'b0100;
    wait_ack(2, a2 + 1, "single_ack");
    bus.port_req = 4'b0000;
    wait_valid(2, v2 + 1, "single_valid");
    repeat (3) tick();
    chk("single_ack_latency", last_ack_cyc[2] - t0, 5);
    chk("single_valid_latency", last_valid_cyc[2] - t0, 10);
    chk("single_ack_once", ack_cnt[2] - a2, 1);
    chk("single_valid_once", valid_cnt[2] - v2, 1);
    chk("single_data_2", bus.port_data_2, 32'hDEADBEEF);
    chk("single_data_0_kept", bus.port_data_0, 32'hC0DE0010);
    chk("single_data_1_kept", bus.port_data_1, 32'hC0DE0022);
    chk("single_data_3_kept", bus.port_data_3, 32'hC0DE03F0);

    // download packing then partial flush
    exp_q.push_back(wr(23'h000002, 32'h44332211));
    exp_q.push_back(wr(23'h000004, 32'h0000BBAA));
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(20'h00004, 8'h11);
    send_byte(20'h00005, 8'h22);
    send_byte(20'h00006, 8'h33);
    chk("pack_busy_before_lane3", bus.dl_busy, 0);
    bus.ioctl_addr = 20'h00007;
    bus.ioctl_data = 8'h44;
    bus.ioctl_wr = 1'b1;
    c = cyc;
    tick();
    bus.ioctl_wr = 1'b0;
    chk("pack_busy_c1", bus.dl_busy, 1);
    chk("pack_req_c1", bus.sdram_req, 0);
    tick();
    chk("pack_req_c2", bus.sdram_req, 1);
    chk("pack_we", bus.sdram_we, 1);
    chk("pack_addr", bus.sdram_addr, 23'h000002);
    chk("pack_data", bus.sdram_data, 32'h44332211);
    repeat (3) tick();
    chk("pack_busy_at_ack", bus.dl_busy, 1);
    tick();
    chk("pack_cycle_check", cyc - c, 6);
    chk("pack_busy_after_ack", bus.dl_busy, 0);
    chk("pack_req_after_ack", bus.sdram_req, 0);
    repeat (4) tick();
    send_byte(20'h00008, 8'hAA);
    send_byte(20'h00009, 8'hBB);
    bus.ioctl_download = 1'b0;
    tick();
    chk("flush_busy", bus.dl_busy, 1);
    tick();
    chk("flush_req", bus.sdram_req, 1);
    chk("flush_we", bus.sdram_we, 1);
    chk("flush_addr", bus.sdram_addr, 23'h000004);
    chk("flush_data", bus.sdram_data, 32'h0000BBAA);
    repeat (8) tick();
    chk("flush_busy_done", bus.dl_busy, 0);
    chk("pack_queue_drained", exp_q.size(), 0);

    // reads blocked during download, served after the last write
    a0 = ack_cnt[0]; v0 = valid_cnt[0];
    exp_q.push_back(wr(23'h000008, 32'h04030201));
    exp_q.push_back(wr(23'h00000A, 32'h00000055));
    exp_q.push_back(rd(0, PA0));
    bus.ioctl_download = 1'b1;
    bus.port_req = 4'b0001;
    tick();
    send_byte(20'h00010, 8'h01);
    send_byte(20'h00011, 8'h02);
    send_byte(20'h00012, 8'h03);
    send_byte(20'h00013, 8'h04);
    send_byte(20'h00014, 8'h55);
    repeat (4) tick();
    chk("block_no_read", ack_cnt[0] - a0, 0);
    bus.ioctl_download = 1'b0;
    wait_ack(0, a0 + 1, "block_ack");
    bus.port_req = 4'b0000;
    wait_valid(0, v0 + 1, "block_valid");
    tick();
    chk("block_read_after_write", last_ack_cyc[0] > last_wr_cyc, 1);
    chk("block_queue_drained", exp_q.size(), 0);
    chk("block_data_0", bus.port_data_0, 32'hC0DE0010);

    // reset in WAIT abandons the read; a late valid is ignored
    a1 = ack_cnt[1]; v1 = valid_cnt[1];
    exp_q.push_back(rd(1, PA1));
    bus.port_req = 4'b0010;
    wait_ack(1, a1 + 1, "rstmid_ack");
    ctl_en = 1'b0;
    bus.port_req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_sdram_req", bus.sdram_req, 0);
    chk("rstmid_sdram_we", bus.sdram_we, 0);
    chk("rstmid_sdram_addr", bus.sdram_addr, 0);
    chk("rstmid_sdram_data", bus.sdram_data, 0);
    chk("rstmid_port_ack", bus.port_ack, 0);
    chk("rstmid_port_valid", bus.port_valid, 0);
    chk("rstmid_port_data_0", bus.port_data_0, 0);
    chk("rstmid_port_data_2", bus.port_data_2, 0);
    chk("rstmid_dl_busy", bus.dl_busy, 0);
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    repeat (4) tick();
    chk("rstmid_no_valid", valid_cnt[1] - v1, 0);

    // after reset the pointer is back at 3, port 3 alone is served normally
    ctl_en = 1'b1;
    a3 = ack_cnt[3]; v3 = valid_cnt[3];
    exp_q.push_back(rd(3, PA3));
    bus.port_req = 4'b1000;
    wait_ack(3, a3 + 1, "post_rst_ack");
    bus.port_req = 4'b0000;
    wait_valid(3, v3 + 1, "post_rst_valid");
    tick();
    chk("post_rst_data_3", bus.port_data_3, 32'hC0DE03F0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller (one-request-at-a-time, 32-bit port, ack/valid handshake) between the ROM download path and four read requesters inside the game core (CPU program ROM, character, tile and sprite fetchers). During download it packs incoming bytes into 32-bit words and issues writes. Otherwise it grants reads round-robin. It returns each read word to the port that requested it.

## Interface
- ADDR_WIDTH, 23: SDRAM word address width (16-bit-word addressing; 32-bit accesses use even addresses).
- DATA_WIDTH, 32: SDRAM data width; fixed at 32 for byte packing.
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_addr  in  20  download byte address.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_download  in  1  high for the whole download.
- dl_busy  out  1  high while a packed write word is pending or in flight.
- port_req[3:0]  in  4  per-port level request, held until that port's ack.
- port_addr_0..3  in  ADDR_WIDTH each  per-port word address; stable while req is high.
- port_ack[3:0]  out  4  one-cycle pulse, request accepted.
- port_valid[3:0]  out  4  one-cycle pulse, port_data_N updated.
- port_data_0..3  out  32 each  last word read for that port; holds value until the next valid.
- sdram_addr  out  ADDR_WIDTH;  sdram_data  out  32;  sdram_we  out  1;  sdram_req  out  1  controller request, held until ack.
- sdram_ack  in  1;  sdram_valid  in  1;  sdram_q  in  32  controller responses.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, selection priority:
  - A pending download word wins: load sdram_addr/data, set we=1, go to REQ.
  - Otherwise, if ioctl_download is low and any port_req is high, grant the first requesting port searching from (last_grant+1) mod 4. Load its address, set we=0, record owner, go to REQ.
  - While ioctl_download is high, read ports are never granted.
- REQ: sdram_req=1 until sdram_ack.
  - Write on ack: go to IDLE and clear the pending flag. No valid is awaited.
  - Read on ack: pulse port_ack[owner] next cycle, update last_grant, go to WAIT.
- WAIT: on sdram_valid, capture sdram_q into port_data_owner, pulse port_valid[owner] next cycle, go to IDLE.
- Byte packing, on ioctl_wr with ioctl_download high:
  - Byte lane = ioctl_addr[1:0], little-endian: lane 0 → bits 7:0.
  - On lane 3, the word is complete. Set pending, with address = {zero-extend, ioctl_addr[19:2], 1'b0}. The shift register is cleared after it is copied.
- Download end: on the falling edge of ioctl_download with bytes accumulated but no lane-3 write, the partial word becomes pending. Its unwritten lanes are 0.
- Overrun: a new word completing while pending is still set overwrites the pending word. The source must keep byte spacing ≥ 8 cycles; dl_busy lets it check this.
- Round-robin pointer last_grant resets to 3, so port 0 wins first.

## Timing
- Reset values: sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0, port_ack=0, port_valid=0, port_data_N=0, dl_busy=0, state=IDLE, pending=0, byte accumulator cleared.
- Reset mid-transaction abandons the access. The controller is reset by the same source.
- Read latency: port_req high at cycle 0 in IDLE → sdram_req high cycle 1. If sdram_ack arrives at cycle a, port_ack pulses at a+1. If sdram_valid arrives at cycle v, port_valid and the data change at v+1, and the FSM is in IDLE at v+1.
- Back-to-back: the next sdram_req is high at v+2.
- Write: lane-3 ioctl_wr at cycle 0 → pending and dl_busy high at 1 → sdram_req high at 2 → dl_busy low the cycle after ack.
- The FSM accepts ack and valid only in the matching state. sdram_ack/valid are ignored elsewhere.
- A port_req dropped before grant is never served. Dropping it after grant is illegal.
- Simultaneous ioctl_download rise and a read in flight: the read completes normally, and downloads then take priority.

## Test plan
- Single read: port 2 req, addr 0x000100; controller acks 3 cycles later and returns 0xDEADBEEF 5 cycles after that → port_ack[2] one pulse, port_valid[2] one pulse, port_data_2=0xDEADBEEF. Other ports unchanged.
- Round-robin: all four reqs held continuously → grant order 0,1,2,3,0. Each port is acked exactly once per 4 grants.
- Download packing: bytes 0x11,0x22,0x33,0x44 at ioctl_addr 0x00004–0x00007 → one write, sdram_addr=0x000002, sdram_data=0x44332211, sdram_we=1.
- Partial flush: bytes 0xAA,0xBB at 0x00008–0x00009, then ioctl_download falls → write addr 0x000004, data 0x0000BBAA.
- Download blocking: ioctl_download high with port_req[0] held → no read issued until download ends and the last write is acked. Then port 0 is served.
- Reset mid-read: assert reset in WAIT → next cycle all outputs at reset values. A later sdram_valid produces no port_valid.
